ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit_if.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage multiply/divide unit bus: operands and control from ID/EX, stall and HI/LO results back.
// master = pipeline side, slave = muldiv unit. state_dbg mirrors the unit FSM (0 IDLE, 1 MUL, 2 DIV, 3 DONE).
interface ex_muldiv_unit_if;
    logic        ex_valid;
    logic        ex_hold;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [1:0]  hiloren;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_dbg;

    // Handshake: an instruction issues when ex_valid && !flush in IDLE; while stall is high the
    // pipeline must keep EX frozen, and the result is architecturally visible the cycle stall drops.
    modport master (
        output ex_valid, ex_hold, flush, op, src_a, src_b, hiloren,
        input  stall, rdata, hi, lo, state_dbg
    );

    modport slave (
        input  ex_valid, ex_hold, flush, op, src_a, src_b, hiloren,
        output stall, rdata, hi, lo, state_dbg
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU (chunked partial products) and DIV/DIVU (restoring radix-2) with HI/LO.
// Operands are latched as magnitudes at issue; signs are re-applied on the completion edge.
module ex_muldiv_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic          clk,
    input  logic          resetn,
    ex_muldiv_unit_if.slave bus
);
    localparam int         CHUNK    = (32 + MUL_CYCLES - 1) / MUL_CYCLES;
    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_nxt;
    logic [63:0] acc, mcand;
    logic [31:0] op_b, rem, quo;
    logic        neg_p, neg_r;
    logic [5:0]  cnt;
    logic [31:0] hi_q, lo_q;

    logic        live, start, is_signed, is_mul;
    logic [31:0] abs_a, abs_b;

    assign live      = bus.ex_valid && !bus.flush;
    assign start     = live && (state == IDLE) && (bus.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign abs_a     = (is_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign abs_b     = (is_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    // Multiply step: the multiplier is consumed CHUNK bits per cycle, low chunk first.
    logic [63:0] mplier_chunk, mul_sum, mul_fin;
    assign mplier_chunk = 64'(op_b[CHUNK-1:0]);
    assign mul_sum      = acc + mcand * mplier_chunk;
    assign mul_fin      = neg_p ? -mul_sum : mul_sum;

    // Divide step: a 33-bit trial subtract; bit 32 set means the divisor did not fit.
    logic [32:0] div_shift, div_diff;
    logic        div_ok;
    logic [31:0] rem_nxt, quo_nxt, q_fin, r_fin;
    assign div_shift = {rem, quo[31]};
    assign div_diff  = div_shift - {1'b0, op_b};
    assign div_ok    = !div_diff[32];
    assign rem_nxt   = div_ok ? div_diff[31:0] : div_shift[31:0];
    assign quo_nxt   = {quo[30:0], div_ok};
    assign q_fin     = neg_p ? -quo_nxt : quo_nxt;
    assign r_fin     = neg_r ? -rem_nxt : rem_nxt;

    logic        hi_we, lo_we;
    logic [31:0] hi_wd, lo_wd;

    always_comb begin
        state_nxt = state;
        bus.stall = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_wd     = hi_q;
        lo_wd     = lo_q;
        case (state)
            IDLE: begin
                if (start) begin
                    bus.stall = 1'b1;
                    state_nxt = is_mul ? MUL : DIV;
                end else if (live && bus.op == OP_MTHI) begin
                    hi_we = 1'b1;
                    hi_wd = bus.src_a;
                end else if (live && bus.op == OP_MTLO) begin
                    lo_we = 1'b1;
                    lo_wd = bus.src_a;
                end
            end
            MUL: begin
                bus.stall = 1'b1;
                if (cnt == MUL_LAST) begin
                    hi_we     = 1'b1;
                    lo_we     = 1'b1;
                    hi_wd     = mul_fin[63:32];
                    lo_wd     = mul_fin[31:0];
                    state_nxt = DONE;
                end
            end
            DIV: begin
                bus.stall = 1'b1;
                if (cnt == DIV_LAST) begin
                    hi_we     = 1'b1;
                    lo_we     = 1'b1;
                    hi_wd     = r_fin;
                    lo_wd     = q_fin;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The finished instruction may still sit in EX under ex_hold; never re-issue it.
                if (!bus.ex_hold) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = IDLE;
            bus.stall = 1'b0;
            hi_we     = 1'b0;
            lo_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc   <= '0;
            mcand <= '0;
            op_b  <= '0;
            rem   <= '0;
            quo   <= '0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mcand <= {32'b0, abs_a};
                        op_b  <= abs_b;
                        rem   <= '0;
                        quo   <= abs_a;
                        neg_p <= is_signed && (bus.src_a[31] ^ bus.src_b[31]);
                        neg_r <= is_signed && bus.src_a[31];
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    acc   <= mul_sum;
                    mcand <= mcand << CHUNK;
                    op_b  <= op_b >> CHUNK;
                    cnt   <= cnt + 6'd1;
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_wd;
            if (lo_we) lo_q <= lo_wd;
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.rdata     = bus.hiloren[1] ? hi_q : (bus.hiloren[0] ? lo_q : 32'd0);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed corner cases plus random ops against an arithmetic model.
// Results are queued as {hi,lo} when an op issues and popped when the unit reports completion.
module tb_ex_muldiv_unit;
    localparam int MUL_CYCLES = 2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic clk;
    logic resetn;
    ex_muldiv_unit_if bus ();

    ex_muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural operands.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] cur_hi,
                                              input logic [31:0] cur_lo);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {cur_hi, cur_lo};
        case (o)
            OP_MULT:  p = 64'(sa * sb);
            OP_MULTU: p = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) begin
                    // all-ones magnitude quotient, negated when the dividend is negative
                    q = a[31] ? 32'd1 : 32'hFFFFFFFF;
                    r = a;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    q  = sq[31:0];
                    r  = sr[31:0];
                end
                p = {r, q};
            end
            OP_DIVU: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else        p = {a % b, a / b};
            end
            OP_MTHI: p = {a, cur_lo};
            OP_MTLO: p = {cur_hi, a};
            default: p = {cur_hi, cur_lo};
        endcase
        return p;
    endfunction

    function automatic int exp_stall(input logic [2:0] o);
        if (o == OP_MULT || o == OP_MULTU) return 1 + MUL_CYCLES;
        if (o == OP_DIV || o == OP_DIVU)   return 33;
        return 0;
    endfunction

    // driver: issue one op at posedge+1, scramble operands while stalled, retire it
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        exp_q.push_back(ref_model(o, a, b, model_hi, model_lo));
        bus.ex_valid = 1'b1;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        cycles       = 0;
        #1;
        while (bus.stall && cycles < 200) begin
            cycles++;
            @(posedge clk);
            #1;
            bus.src_a = $urandom;
            bus.src_b = $urandom;
            #1;
        end
        check("stall_cycles", 64'(cycles), 64'(exp_stall(o)));
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        bus.op       = 3'b000;
        {model_hi, model_lo} = exp_q.pop_front();
        check("hi", 64'(bus.hi), 64'(model_hi));
        check("lo", 64'(bus.lo), 64'(model_lo));
        check("state_idle", 64'(bus.state_dbg), 64'(ST_IDLE));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [1:0]  sel;
        int          cycles;

        resetn       = 1'b0;
        bus.ex_valid = 1'b0;
        bus.ex_hold  = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 3'b000;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.hiloren  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        bus.hiloren = 2'b11;
        #1;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        bus.hiloren = 2'b00;
        resetn = 1'b1;
        tick();

        // directed corners
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFFFFFE_00000001);
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
        check("mult_neg", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFFFFFF_FFFFFFEB);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_neg", {32'(bus.hi), 32'(bus.lo)}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_DIVU, 32'd100, 32'd0);
        check("divu_zero", {32'(bus.hi), 32'(bus.lo)}, 64'h00000064_FFFFFFFF);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf", {32'(bus.hi), 32'(bus.lo)}, 64'h00000000_80000000);

        run_op(OP_MTHI, 32'h12345678, 32'd0);
        bus.hiloren = 2'b10;
        #1;
        check("mfhi", 64'(bus.rdata), 64'h12345678);
        check("mfhi_stall", 64'(bus.stall), 64'd0);
        bus.hiloren = 2'b00;

        // flush in the middle of a divide: no write, back to IDLE, next op runs normally
        bus.ex_valid = 1'b1;
        bus.op       = OP_DIVU;
        bus.src_a    = 32'd12345;
        bus.src_b    = 32'd17;
        #1;
        check("flush_issue_stall", 64'(bus.stall), 64'd1);
        repeat (10) tick();
        bus.flush = 1'b1;
        #1;
        check("flush_stall_drop", 64'(bus.stall), 64'd0);
        tick();
        bus.flush = 1'b0;
        check("flush_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        check("flush_hi", 64'(bus.hi), 64'(model_hi));
        check("flush_lo", 64'(bus.lo), 64'(model_lo));
        run_op(OP_MULTU, 32'd1000, 32'd3000);

        // completion under ex_hold: one write, no re-issue while the op sits in EX
        exp_q.push_back(ref_model(OP_MULTU, 32'hDEADBEEF, 32'h01020304, model_hi, model_lo));
        bus.ex_valid = 1'b1;
        bus.ex_hold  = 1'b1;
        bus.op       = OP_MULTU;
        bus.src_a    = 32'hDEADBEEF;
        bus.src_b    = 32'h01020304;
        cycles       = 0;
        #1;
        while (bus.stall && cycles < 200) begin
            cycles++;
            tick();
        end
        check("hold_stall_cycles", 64'(cycles), 64'(1 + MUL_CYCLES));
        {model_hi, model_lo} = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            check("hold_stall_low", 64'(bus.stall), 64'd0);
            check("hold_state_done", 64'(bus.state_dbg), 64'(ST_DONE));
            check("hold_hilo", {32'(bus.hi), 32'(bus.lo)}, {model_hi, model_lo});
            tick();
        end
        bus.ex_hold = 1'b0;
        #1;
        check("hold_release_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.ex_valid = 1'b0;
        bus.op       = 3'b000;
        check("hold_state_idle", 64'(bus.state_dbg), 64'(ST_IDLE));
        check("hold_hilo_final", {32'(bus.hi), 32'(bus.lo)}, {model_hi, model_lo});

        // random ops with MFHI/MFLO reads in between
        for (int n = 0; n < 30; n++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            run_op(o, a, b);
            sel = 2'($urandom_range(0, 3));
            bus.hiloren = sel;
            #1;
            check("rdata", 64'(bus.rdata), sel[1] ? 64'(model_hi) : (sel[0] ? 64'(model_lo) : 64'd0));
            bus.hiloren = 2'b00;
        end

        // reset in the middle of a divide
        run_op(OP_MTLO, 32'hCAFEF00D, 32'd0);
        bus.ex_valid = 1'b1;
        bus.op       = OP_DIV;
        bus.src_a    = 32'h7654321;
        bus.src_b    = 32'd9;
        repeat (6) tick();
        resetn       = 1'b0;
        bus.ex_valid = 1'b0;
        bus.op       = 3'b000;
        tick();
        model_hi = '0;
        model_lo = '0;
        check("rstdiv_hi", 64'(bus.hi), 64'd0);
        check("rstdiv_lo", 64'(bus.lo), 64'd0);
        check("rstdiv_stall", 64'(bus.stall), 64'd0);
        check("rstdiv_state", 64'(bus.state_dbg), 64'(ST_IDLE));
        resetn = 1'b1;
        tick();
        run_op(OP_DIVU, 32'd1000, 32'd7);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
